// File: rtl/aria_ecb_dout.sv
// aria_ecb_dout: ARIA ECB output unloader. Buffers finished 128-bit blocks
// in an NSLOT-deep slot FIFO and streams each as four 32-bit words.
// Ports: clk, rst (async, active-high), ecb_clr (sync flush),
//   blk_valid/blk_data/blk_ready (block in from round core),
//   dout_valid/dout_data/dout_last/dout_ready (word stream out), busy.
// Build option: ARIA_DOUT_BSWAP_EN byte-reverses every output word.
module aria_ecb_dout #(
    parameter int NSLOT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ecb_clr,
    input  logic         blk_valid,
    input  logic [127:0] blk_data,
    output logic         blk_ready,
    output logic         dout_valid,
    output logic [31:0]  dout_data,
    output logic         dout_last,
    input  logic         dout_ready,
    output logic         busy
);

    localparam logic [1:0] NS = 2'(NSLOT);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [127:0] slot [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic [1:0]   cnt_nxt;
    logic [1:0]   beat;
    logic         acc;
    logic         xfer;
    logic         rel;
    logic [127:0] head;
    logic [31:0]  word;

    // With a single slot both pointers stay parked on entry 0.
    function automatic logic ptr_inc(input logic p);
        return (NSLOT == 1) ? 1'b0 : ~p;
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign blk_ready  = (cnt < NS) & ~ecb_clr;
    assign dout_valid = (state == SEND);
    assign busy       = (cnt != 2'd0);
    assign acc        = blk_valid & blk_ready;
    assign xfer       = dout_valid & dout_ready;
    assign rel        = xfer & (beat == 2'd3);
    assign cnt_nxt    = cnt + {1'b0, acc} - {1'b0, rel};
    assign head       = slot[rd_ptr];

    always_comb begin
        word = head[127:96];
        unique case (beat)
            2'd0: word = head[127:96];
            2'd1: word = head[95:64];
            2'd2: word = head[63:32];
            2'd3: word = head[31:0];
            default: word = head[127:96];
        endcase
    end

`ifdef ARIA_DOUT_BSWAP_EN
    assign dout_data = dout_valid ? bswap(word) : 32'd0;
`else
    assign dout_data = dout_valid ? word : 32'd0;
`endif

    assign dout_last = dout_valid & (beat == 2'd3);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (acc) state_nxt = SEND;
            SEND: if (rel && cnt_nxt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (ecb_clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            beat   <= 2'd0;
            for (int i = 0; i < 2; i++) slot[i] <= '0;
        end else if (ecb_clr) begin
            // Slot contents are left as-is; they are unreachable until
            // overwritten because dout_data is gated by dout_valid.
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            beat   <= 2'd0;
        end else begin
            if (acc) begin
                slot[wr_ptr] <= blk_data;
                wr_ptr       <= ptr_inc(wr_ptr);
            end
            if (xfer) beat <= beat + 2'd1;
            if (rel) rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_aria_ecb_dout.sv
// tb_aria_ecb_dout: directed bench for aria_ecb_dout with a word scoreboard.
// Expected words are queued when a block is offered and popped on transfer.
module tb_aria_ecb_dout;

    logic         clk = 1'b0;
    logic         rst;
    logic         ecb_clr;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         dout_valid;
    logic [31:0]  dout_data;
    logic         dout_last;
    logic         dout_ready;
    logic         busy;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    exp_t sb[$];

    aria_ecb_dout #(.NSLOT(2)) dut (
        .clk(clk), .rst(rst), .ecb_clr(ecb_clr),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
        .dout_valid(dout_valid), .dout_data(dout_data),
        .dout_last(dout_last), .dout_ready(dout_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [127:0] b, input int i);
        logic [31:0] w;
        w = b[127 - 32*i -: 32];
`ifdef ARIA_DOUT_BSWAP_EN
        w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
        return w;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [127:0] b);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.d = exp_word(b, i);
            e.l = (i == 3);
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && !ecb_clr && dout_valid && dout_ready) begin
            chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_word", 128'(dout_data), 128'(e.d));
                chk("sb_last", 128'(dout_last), 128'(e.l));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    localparam logic [127:0] B0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B1 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] B2 = 128'h55555555666666667777777788888888;
    localparam logic [127:0] B3 = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam logic [127:0] B4 = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
    localparam logic [127:0] B5 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] B6 = 128'hcafef00dcafef00dcafef00dcafef00d;
    localparam logic [127:0] B7 = 128'h12345678123456781234567812345678;
    localparam logic [127:0] B8 = 128'hfedcba9876543210fedcba9876543210;
    localparam logic [127:0] B9 = 128'h00112233445566778899aabbccddeeff;

    initial begin
        rst = 1'b1;
        ecb_clr = 1'b0;
        blk_valid = 1'b0;
        blk_data = '0;
        dout_ready = 1'b0;

        @(negedge clk);
        chk("rst_valid", 128'(dout_valid), 128'd0);
        chk("rst_data", 128'(dout_data), 128'd0);
        chk("rst_last", 128'(dout_last), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ready", 128'(blk_ready), 128'd1);
        tick();
        rst = 1'b0;

        // single block, back-to-back words
        blk_valid = 1'b1; blk_data = B0; dout_ready = 1'b1; push(B0);
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_valid", 128'(dout_valid), 128'd1);
            chk("t1_data", 128'(dout_data), 128'(exp_word(B0, i)));
            chk("t1_last", 128'(dout_last), 128'(i == 3));
            tick();
        end
        @(negedge clk);
        chk("t1_busy", 128'(busy), 128'd0);
        chk("t1_idle", 128'(dout_valid), 128'd0);
        chk("t1_zero", 128'(dout_data), 128'd0);

        // back-pressure until full
        tick();
        dout_ready = 1'b0;
        blk_valid = 1'b1; blk_data = B1; push(B1);
        tick();
        blk_data = B2; push(B2);
        tick();
        blk_data = B3;
        @(negedge clk);
        chk("t2_full", 128'(blk_ready), 128'd0);
        chk("t2_busy", 128'(busy), 128'd1);
        chk("t2_hold0", 128'(dout_data), 128'(exp_word(B1, 0)));
        tick();
        tick();
        @(negedge clk);
        chk("t2_full2", 128'(blk_ready), 128'd0);
        chk("t2_hold1", 128'(dout_data), 128'(exp_word(B1, 0)));
        chk("t2_hlast", 128'(dout_last), 128'd0);
        tick();
        blk_valid = 1'b0; dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_nobubble", 128'(dout_valid), 128'd1);
            chk("t2_data", 128'(dout_data),
                128'(exp_word(i < 4 ? B1 : B2, i % 4)));
            tick();
        end
        @(negedge clk);
        chk("t2_drained", 128'(busy), 128'd0);

        // accept on the same edge as the word-3 release
        tick();
        blk_valid = 1'b1; blk_data = B4; push(B4);
        tick();
        blk_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tick();
            if (i == 2) begin
                blk_valid = 1'b1; blk_data = B5; push(B5);
            end
        end
        blk_valid = 1'b0;
        @(negedge clk);
        chk("t3_cnt", 128'(dut.cnt), 128'd1);
        chk("t3_valid", 128'(dout_valid), 128'd1);
        chk("t3_w0", 128'(dout_data), 128'(exp_word(B5, 0)));
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        chk("t3_busy", 128'(busy), 128'd0);

        // flush after two beats with a block offered
        tick();
        blk_valid = 1'b1; blk_data = B6; push(B6);
        tick();
        blk_valid = 1'b0;
        tick();
        tick();
        ecb_clr = 1'b1; blk_valid = 1'b1; blk_data = B7;
        @(negedge clk);
        chk("t4_clr_ready", 128'(blk_ready), 128'd0);
        tick();
        ecb_clr = 1'b0; blk_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("t4_valid", 128'(dout_valid), 128'd0);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_ready", 128'(blk_ready), 128'd1);
        chk("t4_data", 128'(dout_data), 128'd0);
        tick();
        tick();
        @(negedge clk);
        chk("t4_notstored", 128'(busy), 128'd0);

        // async reset during beat 1
        tick();
        blk_valid = 1'b1; blk_data = B8; push(B8);
        tick();
        blk_valid = 1'b0;
        tick();
        #2;
        chk("t5_pre_beat1", 128'(dout_data), 128'(exp_word(B8, 1)));
        rst = 1'b1;
        #1;
        sb.delete();
        chk("t5_valid", 128'(dout_valid), 128'd0);
        chk("t5_data", 128'(dout_data), 128'd0);
        chk("t5_last", 128'(dout_last), 128'd0);
        chk("t5_ready", 128'(blk_ready), 128'd1);
        chk("t5_busy", 128'(busy), 128'd0);
        tick();
        rst = 1'b0;

        // byte-order check block
        tick();
        blk_valid = 1'b1; blk_data = B9; push(B9);
        tick();
        blk_valid = 1'b0;
        @(negedge clk);
`ifdef ARIA_DOUT_BSWAP_EN
        chk("t6_w0", 128'(dout_data), 128'h33221100);
`else
        chk("t6_w0", 128'(dout_data), 128'h00112233);
`endif
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        chk("sb_drained", 128'(sb.size()), 128'd0);
        chk("t6_busy", 128'(busy), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
